// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush and a saturating count of inserted bubbles.
module idex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_busa,
    input  logic [DATA_W-1:0] id_busb,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_aluctr,
    input  logic              id_alusrc,
    input  logic              id_regwr,
    input  logic              id_memwr,
    input  logic              id_memtoreg,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              idex_valid,
    output logic [REG_W-1:0]  idex_rs,
    output logic [REG_W-1:0]  idex_rt,
    output logic [REG_W-1:0]  idex_rd,
    output logic [DATA_W-1:0] idex_busa,
    output logic [DATA_W-1:0] idex_busb,
    output logic [DATA_W-1:0] idex_imm,
    output logic [3:0]        idex_aluctr,
    output logic              idex_alusrc,
    output logic              idex_regwr,
    output logic              idex_memwr,
    output logic              idex_memtoreg,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] busa;
        logic [DATA_W-1:0] busb;
        logic [DATA_W-1:0] imm;
        logic [3:0]        aluctr;
        logic              alusrc;
        logic              regwr;
        logic              memwr;
        logic              memtoreg;
    } idex_t;

    idex_t            q;
    idex_t            d_cap;
    logic             luse;
    logic             bubble;
    logic             rs_hit;
    logic             rt_hit;
    logic [CNT_W-1:0] cnt;

    // An invalid ID slot must never write architectural state downstream.
    always_comb begin
        d_cap          = '0;
        d_cap.valid    = id_valid;
        d_cap.rs       = id_rs;
        d_cap.rt       = id_rt;
        d_cap.rd       = id_rd;
        d_cap.busa     = id_busa;
        d_cap.busb     = id_busb;
        d_cap.imm      = id_imm;
        d_cap.aluctr   = id_aluctr;
        d_cap.alusrc   = id_alusrc;
        d_cap.regwr    = id_regwr & id_valid;
        d_cap.memwr    = id_memwr & id_valid;
        d_cap.memtoreg = id_memtoreg;
    end

    assign rs_hit = (q.rd == id_rs);
    assign rt_hit = id_uses_rt & (q.rd == id_rt);

    // $0 is never a real dependency, so a load into it cannot stall.
    assign luse = q.valid & q.memtoreg & q.regwr & (q.rd != '0)
                & id_valid & (rs_hit | rt_hit);

    assign bubble = flush | luse;
    assign stall  = !rst & (ex_hold | (luse & !flush));

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            cnt <= '0;
        end else if (!ex_hold) begin
            if (bubble) begin
                q <= '0;
                if (cnt != '1)
                    cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                q <= d_cap;
            end
        end
    end

    assign idex_valid    = q.valid;
    assign idex_rs       = q.rs;
    assign idex_rt       = q.rt;
    assign idex_rd       = q.rd;
    assign idex_busa     = q.busa;
    assign idex_busb     = q.busb;
    assign idex_imm      = q.imm;
    assign idex_aluctr   = q.aluctr;
    assign idex_alusrc   = q.alusrc;
    assign idex_regwr    = q.regwr;
    assign idex_memwr    = q.memwr;
    assign idex_memtoreg = q.memtoreg;
    assign bubble_cnt    = cnt;

endmodule
